byte_serializer: RTL and testbench
==================================

Name: byte_serializer

Overview:
- Downstream consumer of the two-byte transmit sequencer.
- Accepts one 8-bit byte per send_byte pulse and shifts it out on TX as a UART frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts BAUD_DIV clocks.
- Returns a one-cycle byte_sent pulse when the frame is complete, so the sequencer can launch the next byte.

Parameters:
- BAUD_DIV, 2604, clocks per bit (2604 gives 19200 baud at 50 MHz). Legal range is 2 or more; the bench uses 4.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk
- send_byte  input  1  request to transmit tx_byte; level sampled each clock
- tx_byte  input  8  byte to transmit; captured only on the accepting edge
- TX  output  1  serial line, registered; idles high
- busy  output  1  high while a frame is in progress
- byte_sent  output  1  one-cycle pulse marking frame completion

Behaviour:
- Reset: any rising edge with rst_n=0 forces the following, regardless of state, including mid-frame:
  - state=IDLE, TX=1, busy=0, byte_sent=0
  - baud counter=0, bit counter=0, shift register=all ones
  - A frame aborted by reset is not resumed, and byte_sent is not pulsed for it.
- States: IDLE and SHIFT. Use a 2-state encoded enum with a registered state.
- IDLE:
  - TX=1, busy=0.
  - On an edge with send_byte=1: load shift register {1'b1, tx_byte, 1'b0} (10 bits), clear the baud and bit counters, and go to SHIFT.
- SHIFT, timing:
  - Call the accepting edge k. From edge k, TX=shift_reg[0]=0 (start bit) and busy=1.
  - The baud counter increments each clock. When it reaches BAUD_DIV-1 it wraps to 0, the shift register shifts right with 1 filled in at the MSB, and the bit counter increments.
  - The TX value for bit n (n=0..9) is therefore held from edge k+n*BAUD_DIV to edge k+(n+1)*BAUD_DIV.
- Frame end:
  - When the bit counter reaches 10, at edge k+10*BAUD_DIV: state=IDLE, busy=0, TX=1, byte_sent=1 for exactly that one cycle.
  - Total frame length is 10*BAUD_DIV clocks.
- Back-to-back:
  - send_byte=1 during the cycle byte_sent=1 is accepted at the next edge, since the state is already IDLE.
  - The result is at most one idle-high cycle between the stop bit and the next start bit. This one cycle is required, because the sequencer drives send_byte combinationally from byte_sent.
- send_byte while busy: ignored entirely. No queuing, no restart, and tx_byte is not re-captured.
- tx_byte changes after the accepting edge: no effect on the frame in progress.
- byte_sent is asserted only at normal frame completion, never in any other cycle.
- Widths:
  - Baud counter is $clog2(BAUD_DIV) bits.
  - Bit counter is 4 bits and never exceeds 10.
  - No other arithmetic.
- No combinational path from any input to any output. TX, busy and byte_sent are all flop outputs.

Test Plan:
- Reset: BAUD_DIV=4, hold rst_n=0 for 3 clocks with send_byte=1 -> TX=1, busy=0, byte_sent=0 throughout; no frame starts.
- Single frame:
  - Stimulus: tx_byte=8'hA5, 1-cycle send_byte at edge k.
  - Required TX: 0 for edges k..k+4, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then 1 (stop).
  - Required status: busy=1 for 40 cycles; byte_sent=1 only in the cycle after edge k+40.
- Back-to-back:
  - Stimulus: model the sequencer; raise send_byte with tx_byte=8'h3C in the byte_sent cycle of a frame carrying 8'hFF.
  - Required: second start bit begins at the next edge; exactly one idle-high cycle between frames; 8'h3C bits correct.
- Busy ignore: pulse send_byte with tx_byte=8'h00 at frame cycle 17 of an 8'h81 frame -> frame continues unchanged as 8'h81; only one byte_sent pulse.
- Data hold: change tx_byte from 8'h5A to 8'hFF one cycle after acceptance -> TX shows 8'h5A.
- Reset mid-frame: rst_n=0 for one edge at frame cycle 22 -> TX=1 and busy=0 after that edge; no byte_sent; a new send_byte afterwards gives a full, correct frame.

Source files
------------

// File: rtl/byte_serializer.sv
// UART-style byte serializer: 1 start bit, 8 data bits LSB first, 1 stop bit, BAUD_DIV clocks per bit.
// Latency: start bit on TX the edge send_byte is accepted; byte_sent pulses 10*BAUD_DIV clocks later.
// Backpressure: busy high for the whole frame; send_byte during busy is dropped, never queued.
module byte_serializer #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_byte,
    input  logic [7:0] tx_byte,
    output logic       TX,
    output logic       busy,
    output logic       byte_sent
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          byte_sent_q, byte_sent_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '1;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            byte_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            byte_sent_q <= byte_sent_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        byte_sent_d = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (send_byte) begin
                    shift_d    = {1'b1, tx_byte, 1'b0};
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b1, shift_q[9:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    tx_d       = shift_q[1];
                    // Tenth bit period ends here: back to IDLE so a send_byte
                    // raised during the byte_sent cycle is taken on the next edge.
                    if (bit_cnt_q == 4'd9) begin
                        state_d     = IDLE;
                        tx_d        = 1'b1;
                        busy_d      = 1'b0;
                        byte_sent_d = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign TX        = tx_q;
    assign busy      = busy_q;
    assign byte_sent = byte_sent_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer with BAUD_DIV=4; expected bytes are queued
// when a send is driven and popped when the frame is observed on TX.
module tb_byte_serializer;

    localparam int BD = 4;

    logic       clk;
    logic       rst_n;
    logic       send_byte;
    logic [7:0] tx_byte;
    logic       TX;
    logic       busy;
    logic       byte_sent;

    int         n_cmp;
    int         n_err;
    logic [7:0] exp_q[$];

    byte_serializer #(.BAUD_DIV(BD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .send_byte (send_byte),
        .tx_byte   (tx_byte),
        .TX        (TX),
        .busy      (busy),
        .byte_sent (byte_sent)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic e_tx, input logic e_busy, input logic e_sent);
        chk({tag, ".tx"}, TX, e_tx);
        chk({tag, ".busy"}, busy, e_busy);
        chk({tag, ".byte_sent"}, byte_sent, e_sent);
    endtask

    // Drive a request on the falling edge; it is accepted on the next rising edge.
    task automatic start(input logic [7:0] b);
        send_byte = 1'b1;
        tx_byte   = b;
        exp_q.push_back(b);
        @(negedge clk);
    endtask

    // Called on the falling edge just after the accepting edge.
    // ev_kind: 0 none, 1 send pulse while busy, 2 change tx_byte, 3 reset pulse.
    task automatic run_frame(input string name, input int ev_cycle, input int ev_kind,
                             input logic [7:0] ev_byte);
        logic [7:0] exp;
        logic [9:0] fr;
        exp = exp_q.pop_front();
        fr  = {1'b1, exp, 1'b0};
        for (int j = 0; j < 10 * BD; j++) begin
            chk_line($sformatf("%s.c%0d", name, j), fr[j / BD], 1'b1, 1'b0);
            send_byte = 1'b0;
            if (j == ev_cycle) begin
                case (ev_kind)
                    1: begin send_byte = 1'b1; tx_byte = ev_byte; end
                    2: tx_byte = ev_byte;
                    3: begin
                        rst_n = 1'b0;
                        @(negedge clk);
                        rst_n = 1'b1;
                        for (int r = 0; r < 12 * BD; r++) begin
                            chk_line($sformatf("%s.abort%0d", name, r), 1'b1, 1'b0, 1'b0);
                            @(negedge clk);
                        end
                        return;
                    end
                    default: ;
                endcase
            end
            @(negedge clk);
        end
        chk_line({name, ".end"}, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic idle_check(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk_line($sformatf("%s.idle%0d", name, i), 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        send_byte = 1'b1;
        tx_byte   = 8'hA5;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_line($sformatf("reset%0d", i), 1'b1, 1'b0, 1'b0);
        end
        rst_n     = 1'b1;
        send_byte = 1'b0;
        idle_check("post_reset", 3);

        start(8'hA5);
        run_frame("a5", -1, 0, 8'h00);
        send_byte = 1'b0;
        idle_check("after_a5", 2);

        // Sequencer model: next byte requested in the byte_sent cycle.
        start(8'hFF);
        run_frame("ff", -1, 0, 8'h00);
        start(8'h3C);
        run_frame("3c", -1, 0, 8'h00);
        send_byte = 1'b0;
        idle_check("after_3c", 2);

        start(8'h81);
        run_frame("81", 17, 1, 8'h00);
        send_byte = 1'b0;
        idle_check("after_81", 4 * BD);

        start(8'h5A);
        run_frame("5a", 0, 2, 8'hFF);
        send_byte = 1'b0;
        idle_check("after_5a", 2);

        start(8'h96);
        run_frame("abort", 22, 3, 8'h00);
        start(8'hC3);
        run_frame("c3", -1, 0, 8'h00);
        send_byte = 1'b0;
        idle_check("after_c3", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
